// File: rtl/gfx_pkg.sv
// ============================================================================
// Module : gfx_pkg
// Brief  : Shared gfx helpers (lane-index width).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package gfx_pkg;

  function automatic int gfx_idx_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gfx_serialize_pick.sv
// ============================================================================
// Module : gfx_serialize_pick
// Brief  : Lane priority encoder: next set lane above idx and lowest set lane.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gfx_serialize_pick
  import gfx_pkg::*;
#(
  parameter int COUNT = 4,
  parameter int IDX_W = gfx_idx_w(COUNT)
) (
  input  logic [COUNT-1:0] i_mask,
  input  logic [IDX_W-1:0] i_idx,
  output logic [IDX_W-1:0] o_next_idx,
  output logic             o_any_next,
  output logic [IDX_W-1:0] o_first_idx,
  output logic             o_any_set
);

  // Scan high to low so the lowest qualifying lane is the last one written.
  always_comb begin
    o_next_idx  = '0;
    o_any_next  = 1'b0;
    o_first_idx = '0;
    o_any_set   = 1'b0;
    for (int i = COUNT - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_first_idx = IDX_W'(i);
        o_any_set   = 1'b1;
        if (i > int'(i_idx)) begin
          o_next_idx = IDX_W'(i);
          o_any_next = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gfx_serialize.sv
// ============================================================================
// Module : gfx_serialize
// Brief  : Wide-to-narrow converter, lane 0 first, zero-bubble between words.
//          Optional per-lane skip mask under macro GFX_SERIALIZE_MASK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gfx_serialize
  import gfx_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int COUNT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH*COUNT-1:0] in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out,
  output logic                   out_last
`ifdef GFX_SERIALIZE_MASK_EN
  ,
  input  logic [COUNT-1:0]       in_mask
`endif
);

  localparam int               c_IDX_W = gfx_idx_w(COUNT);
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(COUNT - 1);

  logic [WIDTH*COUNT-1:0] r_hold;
  logic [c_IDX_W-1:0]     r_idx;
  logic                   r_busy;

  logic [WIDTH-1:0]       w_lanes [COUNT];
  logic [c_IDX_W-1:0]     w_next_idx;
  logic                   w_last;
  logic [c_IDX_W-1:0]     w_first_idx;
  logic                   w_first_any;
  logic                   w_accept;
  logic                   w_beat;

  for (genvar g = 0; g < COUNT; g++) begin : g_lane
    assign w_lanes[g] = r_hold[g*WIDTH +: WIDTH];
  end

`ifdef GFX_SERIALIZE_MASK_EN
  logic [COUNT-1:0]   r_mask;
  logic               w_any_next;
  logic [c_IDX_W-1:0] w_unused_cur_first;
  logic               w_unused_cur_any;
  logic [c_IDX_W-1:0] w_unused_in_next;
  logic               w_unused_in_any_next;

  gfx_serialize_pick #(.COUNT(COUNT), .IDX_W(c_IDX_W)) u_pick_cur (
    .i_mask      (r_mask),
    .i_idx       (r_idx),
    .o_next_idx  (w_next_idx),
    .o_any_next  (w_any_next),
    .o_first_idx (w_unused_cur_first),
    .o_any_set   (w_unused_cur_any)
  );

  gfx_serialize_pick #(.COUNT(COUNT), .IDX_W(c_IDX_W)) u_pick_in (
    .i_mask      (in_mask),
    .i_idx       ('0),
    .o_next_idx  (w_unused_in_next),
    .o_any_next  (w_unused_in_any_next),
    .o_first_idx (w_first_idx),
    .o_any_set   (w_first_any)
  );

  assign w_last = !w_any_next;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mask <= in_mask;
    end
  end
`else
  assign w_next_idx  = r_idx + c_IDX_W'(1);
  assign w_last      = (r_idx == c_LAST);
  assign w_first_idx = '0;
  assign w_first_any = 1'b1;
`endif

  assign out_valid = r_busy;
  assign out       = w_lanes[r_idx];
  assign out_last  = r_busy && w_last;
  // Reset gating keeps upstream from handshaking while the block is held.
  assign in_ready  = !rst && (!r_busy || (out_ready && out_last));
  assign w_accept  = in_valid && in_ready;
  assign w_beat    = r_busy && out_ready;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold <= in;
    end
  end

  // An accept on the last beat takes priority, giving back-to-back words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_busy <= w_first_any;
      r_idx  <= w_first_any ? w_first_idx : '0;
    end else if (w_beat) begin
      if (w_last) begin
        r_busy <= 1'b0;
        r_idx  <= '0;
      end else begin
        r_idx  <= w_next_idx;
      end
    end
  end

endmodule

`default_nettype wire
